llsc_monitor: RTL
=================

Name: llsc_monitor

Overview:
- Controller for the LL/SC link bit in the memory stage.
- Tracks one reservation (link state plus linked address) and decides SC success.
- Drives write-enable/data to the LLbit register mirror in CP0.
- Breaks the reservation on exception flush, conflicting writes or timeout.

Parameters:
- ADDR_W, 32, physical address width.
- GRAN_LSB, 2, low address bits ignored for the reservation match (4-byte granule).
- LINK_TIMEOUT, 1024, cycles a link may stay set before it expires; 0 disables expiry.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  exception/ERET pipeline flush.
- mem_valid  in  1  memory-stage instruction valid and not stalled (executes this cycle).
- mem_ll  in  1  instruction is LL.
- mem_sc  in  1  instruction is SC.
- mem_store  in  1  instruction is an ordinary store (SB/SH/SW/SWL/SWR).
- mem_addr  in  ADDR_W  effective physical address.
- snoop_valid  in  1  write by another bus master (DMA/other core) this cycle.
- snoop_addr  in  ADDR_W  address of that write.
- sc_success  out  1  combinational; current SC succeeds (value written to rt).
- sc_do_write  out  1  combinational; allow the SC memory write (= sc_success).
- llbit_we  out  1  combinational write enable to the LLbit register.
- llbit_wdata  out  1  combinational write data to the LLbit register.
- linked  out  1  registered link state.
- link_addr  out  ADDR_W  registered linked address.

Behaviour:
- Reset (async, rst_n low): state IDLE, link_addr 0, timeout counter 0, linked 0. All combinational outputs evaluate to 0.
- Two states: IDLE and LINKED. linked = (state == LINKED).
- Match rule: addresses are compared on bits [ADDR_W-1:GRAN_LSB] only.
- Next-state priority, evaluated each cycle:
  1. flush: go to IDLE. An LL/SC in the same cycle is ignored, sc_success = 0.
  2. mem_valid & mem_ll: go to LINKED. link_addr <= mem_addr, counter <= 0. Applies in either state (re-link).
  3. mem_valid & mem_sc: go to IDLE regardless of outcome.
  4. snoop_valid and snoop_addr matches link_addr while LINKED: go to IDLE.
  5. Counter == LINK_TIMEOUT-1 while LINKED and LINK_TIMEOUT != 0: go to IDLE.
  6. Otherwise hold. The counter increments while LINKED and stays 0 in IDLE.
- sc_success = mem_valid & mem_sc & !flush & linked & match(mem_addr, link_addr), with two same-cycle kill conditions:
  - It is forced to 0 if a matching snoop occurs in the same cycle (conservative).
  - It is forced to 0 on the expiry cycle.
- An SC in IDLE, or to a non-matching address, fails: sc_success = 0, no memory write, state stays or becomes IDLE.
- llbit_we = flush | (mem_valid & (mem_ll | mem_sc)) | (state change LINKED->IDLE from rules 4/5).
- llbit_wdata = next-state linked value.
- The counter saturates and never wraps.
- Snoop hits while IDLE are ignored.
- Reset asserted mid-link drops the link immediately (async).

Optional Feature:
- Macro LLSC_OWN_STORE_KILL_EN.
- Defined: an ordinary store from this core (mem_valid & mem_store) matching link_addr while LINKED clears the link. It has the same priority slot as a snoop hit and also drives llbit_we.
- Undefined: mem_store is ignored (port retained, unused), and only external snoops, SC, flush or timeout break the link.

Decomposition:
- Shared package: llsc_state_t enum {LLSC_IDLE, LLSC_LINKED}, and addr_t-based granule-compare width constant derived from GRAN_LSB.
- One natural sub-module, llsc_timeout_ctr: saturating counter with clear/enable and an expiry flag, parameterised by LINK_TIMEOUT; when LINK_TIMEOUT = 0 it is tied off.
- Everything else stays in llsc_monitor.

Test Plan:
- LL 0x1000, then SC 0x1000 three cycles later -> sc_success=1 and llbit_we=1/wdata=0 in the SC cycle; linked=0 next cycle.
- LL 0x1000, then SC 0x1004 -> sc_success=0, linked=0 after.
- LL 0x2000, then snoop 0x2003 (same granule) -> linked=0 next cycle and llbit_we pulses with wdata=0; later SC 0x2000 -> sc_success=0.
- LL 0x3000, SC 0x3000 with flush the same cycle -> sc_success=0, linked=0.
- LINK_TIMEOUT=8: LL, then idle 8 cycles -> link clears on the expiry cycle; SC after that -> 0. SC at cycle 7 -> 1.
- With LLSC_OWN_STORE_KILL_EN: LL 0x4000, SW 0x4000, SC 0x4000 -> sc_success=0. Without the macro the same sequence gives sc_success=1.

Source files
------------

// File: rtl/llsc_monitor_pkg.sv
// llsc_monitor_pkg: shared types and constants for the LL/SC link monitor.
//   Provides the link state enum, default address geometry and the width of
//   the granule-compare field (address bits above GRAN_LSB).
package llsc_monitor_pkg;
   localparam int LLSC_ADDR_W   = 32;
   localparam int LLSC_GRAN_LSB = 2;
   localparam int LLSC_CMP_W    = LLSC_ADDR_W - LLSC_GRAN_LSB;
   typedef logic [LLSC_ADDR_W-1:0] addr_t;
   typedef enum logic {LLSC_IDLE, LLSC_LINKED} llsc_state_t;
endpackage

// File: rtl/llsc_timeout_ctr.sv
// llsc_timeout_ctr: saturating link-age counter with clear/enable and expiry flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to 0 (wins over en)
//   en         : count up by one, saturating at LINK_TIMEOUT-1
//   expired    : count has reached LINK_TIMEOUT-1 (constant 0 when LINK_TIMEOUT = 0)
module llsc_timeout_ctr #(
   parameter int LINK_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   generate
      if (LINK_TIMEOUT == 0) begin : g_off
         logic unused;
         assign unused  = ^{clk, rst_n, clr, en};
         assign expired = 1'b0;
      end else begin : g_on
         localparam int CW = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;
         localparam logic [CW-1:0] LAST = CW'(LINK_TIMEOUT - 1);
         logic [CW-1:0] cnt_q, cnt_d;
         always_comb cnt_d = clr ? '0 : (en && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
         assign expired = cnt_q == LAST;
      end
   endgenerate
endmodule

// File: rtl/llsc_monitor.sv
// llsc_monitor: LL/SC reservation tracker and SC success decision for the memory stage.
//   clk, rst_n             : clock, asynchronous active-low reset
//   flush                  : exception/ERET flush, drops the link
//   mem_valid/ll/sc/store  : executing memory-stage instruction and its kind
//   mem_addr               : its effective physical address
//   snoop_valid/snoop_addr : write by another bus master
//   sc_success/sc_do_write : SC result and memory write permission
//   llbit_we/llbit_wdata   : update of the CP0 LLbit mirror
//   linked/link_addr       : registered reservation
//   Optional macro LLSC_OWN_STORE_KILL_EN: a matching ordinary store from this
//   core also breaks the link.
module llsc_monitor
   import llsc_monitor_pkg::*;
#(
   parameter int ADDR_W       = LLSC_ADDR_W,
   parameter int GRAN_LSB     = LLSC_GRAN_LSB,
   parameter int LINK_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic              mem_ll,
   input  logic              mem_sc,
   input  logic              mem_store,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              snoop_valid,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              sc_success,
   output logic              sc_do_write,
   output logic              llbit_we,
   output logic              llbit_wdata,
   output logic              linked,
   output logic [ADDR_W-1:0] link_addr
);
   llsc_state_t       state_q, state_d;
   logic [ADDR_W-1:0] link_addr_q, link_addr_d;
   logic ll_go, sc_go, mem_match, snoop_hit, store_hit, expire, expired;
   assign linked    = state_q == LLSC_LINKED;
   assign link_addr = link_addr_q;
   assign ll_go     = mem_valid & mem_ll & ~flush;
   assign sc_go     = mem_valid & mem_sc & ~flush;
   assign mem_match = (mem_addr >> GRAN_LSB) == (link_addr_q >> GRAN_LSB);
   assign snoop_hit = linked & snoop_valid & ((snoop_addr >> GRAN_LSB) == (link_addr_q >> GRAN_LSB));
   assign expire    = linked & expired;
`ifdef LLSC_OWN_STORE_KILL_EN
   assign store_hit = linked & mem_valid & mem_store & mem_match;
`else
   logic unused_store;
   assign unused_store = mem_store;
   assign store_hit    = 1'b0;
`endif
   always_comb begin
      state_d     = flush ? LLSC_IDLE : ll_go ? LLSC_LINKED : sc_go ? LLSC_IDLE :
                    (snoop_hit | store_hit | expire) ? LLSC_IDLE : state_q;
      link_addr_d = ll_go ? mem_addr : link_addr_q;
      // A same-cycle matching snoop or expiry kills the SC conservatively.
      sc_success  = sc_go & linked & mem_match & ~snoop_hit & ~expire;
      // Any LINKED->IDLE transition covers the snoop/store/timeout breaks.
      llbit_we    = flush | (mem_valid & (mem_ll | mem_sc)) | (linked & state_d == LLSC_IDLE);
      llbit_wdata = state_d == LLSC_LINKED;
   end
   assign sc_do_write = sc_success;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= LLSC_IDLE;
         link_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         link_addr_q <= link_addr_d;
      end
   llsc_timeout_ctr #(.LINK_TIMEOUT(LINK_TIMEOUT)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ll_go | state_d == LLSC_IDLE),
      .en      (linked),
      .expired (expired)
   );
endmodule
